// File: rtl/horner_pkg.sv
// Shared types and defaults for the quadratic evaluator issue stage.
package horner_pkg;

  localparam int unsigned DefW       = 32;
  localparam int unsigned DefEvalLat = 2;
  localparam int unsigned DefDepth   = 4;

  localparam logic [1:0] CFG_C0     = 2'd0;
  localparam logic [1:0] CFG_C1     = 2'd1;
  localparam logic [1:0] CFG_C2     = 2'd2;
  localparam logic [1:0] CFG_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StCommit
  } horner_state_e;

endpackage

// File: rtl/horner_res_fifo.sv
// Result FIFO holding {z, x} pairs; contents are cleared on reset so the head reads zero.
module horner_res_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_rd;

  // A read of an empty FIFO is dropped; writes are never blocked here.
  assign do_rd   = rd_i && !empty_o;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_i, do_rd})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/horner_issue.sv
// Issue/collect stage for z = c0 + c1*x + c2*x^2 with drain-before-commit coefficient updates.
// Optional HORNER_ISSUE_STATS_EN adds issued/stall counters.
module horner_issue
  import horner_pkg::*;
#(
  parameter int unsigned W        = DefW,
  parameter int unsigned EVAL_LAT = DefEvalLat,
  parameter int unsigned DEPTH    = DefDepth
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cfg_we_i,
  input  logic [1:0]   cfg_addr_i,
  input  logic [W-1:0] cfg_wdata_i,
  output logic         cfg_busy_o,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_x_i,
  output logic [W-1:0] ev_x_o,
  output logic [W-1:0] ev_c0_o,
  output logic [W-1:0] ev_c1_o,
  output logic [W-1:0] ev_c2_o,
  input  logic [W-1:0] ev_z_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_z_o,
  output logic [W-1:0] m_x_o
`ifdef HORNER_ISSUE_STATS_EN
  ,
  output logic [31:0]  stat_issued_o,
  output logic [31:0]  stat_stall_o
`endif
);

  localparam int unsigned TagN = EVAL_LAT + 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  horner_state_e state_q;
  logic          busy_q;
  logic [W-1:0]  sh_c0_q, sh_c1_q, sh_c2_q;
  logic [W-1:0]  act_c0_q, act_c1_q, act_c2_q;
  logic [W-1:0]  ev_x_q, ev_c0_q, ev_c1_q, ev_c2_q;
  logic [TagN-1:0] tag_v_q;
  logic [W-1:0]  tag_x_q [TagN];

  logic [CntW-1:0] inflight;
  logic [CntW-1:0] fifo_cnt;
  logic [SumW-1:0] credits;
  logic            fifo_full, fifo_empty;
  logic [2*W-1:0]  fifo_rdata;
  logic            accept, commit_req, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < TagN; i++) inflight = inflight + CntW'(tag_v_q[i]);
  end

  // Every in-flight tag owns a FIFO slot, so the FIFO can never overflow.
  assign credits    = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign s_ready_o  = (state_q == StRun) && (credits < SumW'(DEPTH));
  assign accept     = s_valid_i && s_ready_o;
  assign commit_req = cfg_we_i && (cfg_addr_i == CFG_COMMIT);
  assign push       = tag_v_q[TagN-1];
  assign pop        = m_valid_o && m_ready_i;

  assign cfg_busy_o = busy_q;
  assign ev_x_o     = ev_x_q;
  assign ev_c0_o    = ev_c0_q;
  assign ev_c1_o    = ev_c1_q;
  assign ev_c2_o    = ev_c2_q;
  assign m_valid_o  = !fifo_empty;
  assign m_z_o      = fifo_rdata[2*W-1:W];
  assign m_x_o      = fifo_rdata[W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      busy_q   <= 1'b0;
      sh_c0_q  <= '0;
      sh_c1_q  <= '0;
      sh_c2_q  <= '0;
      act_c0_q <= '0;
      act_c1_q <= '0;
      act_c2_q <= '0;
      ev_x_q   <= '0;
      ev_c0_q  <= '0;
      ev_c1_q  <= '0;
      ev_c2_q  <= '0;
    end else begin
      if (cfg_we_i) begin
        case (cfg_addr_i)
          CFG_C0:  sh_c0_q <= cfg_wdata_i;
          CFG_C1:  sh_c1_q <= cfg_wdata_i;
          CFG_C2:  sh_c2_q <= cfg_wdata_i;
          default: ;
        endcase
      end
      // Operands come from the active set, so a same-edge commit never affects this sample.
      if (accept) begin
        ev_x_q  <= s_x_i;
        ev_c0_q <= act_c0_q;
        ev_c1_q <= act_c1_q;
        ev_c2_q <= act_c2_q;
      end
      case (state_q)
        StRun: begin
          if (commit_req) begin
            state_q <= StDrain;
            busy_q  <= 1'b1;
          end
        end
        StDrain: begin
          if (inflight == '0) state_q <= StCommit;
        end
        StCommit: begin
          act_c0_q <= sh_c0_q;
          act_c1_q <= sh_c1_q;
          act_c2_q <= sh_c2_q;
          state_q  <= StRun;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= StRun;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v_q <= '0;
      for (int i = 0; i < TagN; i++) tag_x_q[i] <= '0;
    end else begin
      tag_v_q    <= {tag_v_q[TagN-2:0], accept};
      tag_x_q[0] <= s_x_i;
      for (int i = 1; i < TagN; i++) tag_x_q[i] <= tag_x_q[i-1];
    end
  end

  horner_res_fifo #(
    .Width (2 * W),
    .Depth (DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_i    (push),
    .wdata_i ({ev_z_i, tag_x_q[TagN-1]}),
    .rd_i    (pop),
    .rdata_o (fifo_rdata),
    .cnt_o   (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

`ifdef HORNER_ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (accept) stat_issued_q <= stat_issued_q + 32'd1;
      if (s_valid_i && !s_ready_o) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued_o = stat_issued_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_horner_issue.sv
// Scoreboard bench for horner_issue with a 2-stage behavioural evaluator.
module tb_horner_issue;
  import horner_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [W-1:0] cfg_wdata = '0;
  logic         cfg_busy;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_x = '0;
  logic [W-1:0] ev_x, ev_c0, ev_c1, ev_c2;
  logic [W-1:0] ev_z;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_z, m_x;
`ifdef HORNER_ISSUE_STATS_EN
  logic [31:0]  stat_issued, stat_stall;
`endif

  horner_issue dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_busy_o  (cfg_busy),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_x_i       (s_x),
    .ev_x_o      (ev_x),
    .ev_c0_o     (ev_c0),
    .ev_c1_o     (ev_c1),
    .ev_c2_o     (ev_c2),
    .ev_z_i      (ev_z),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_z_o       (m_z),
    .m_x_o       (m_x)
`ifdef HORNER_ISSUE_STATS_EN
    ,
    .stat_issued_o (stat_issued),
    .stat_stall_o  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Evaluator: two register stages from operand registers to ev_z.
  logic [W-1:0] p1_q = '0, p2_q = '0;
  always @(posedge clk) begin
    p1_q <= ev_c0 + ev_c1 * ev_x + ev_c2 * ev_x * ev_x;
    p2_q <= p1_q;
  end
  assign ev_z = p2_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed result against the scoreboard head.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got z=%0d x=%0d, expected none", m_z, m_x);
      end else begin
        e = exp_q.pop_front();
        check("result_z", {32'd0, m_z}, {32'd0, e[2*W-1:W]});
        check("result_x", {32'd0, m_x}, {32'd0, e[W-1:0]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [W-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] z, input bit track);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_x = x;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got s_ready=0, expected 1 within 50 cycles");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) exp_q.push_back({z, x});
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    cyc(2);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (cfg_busy && t < 50) begin
      t++;
      @(negedge clk);
    end
    check("commit_done", {63'd0, cfg_busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] xs [6] = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
  logic [W-1:0] zs [6] = '{32'd30, 32'd40, 32'd52, 32'd66, 32'd82, 32'd100};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int  idx;
    bit  acc;

    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd1);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_busy", {63'd0, cfg_busy}, 64'd0);
    check("rst_ev_x", {32'd0, ev_x}, 64'd0);
    check("rst_ev_c0", {32'd0, ev_c0}, 64'd0);
    check("rst_m_z", {32'd0, m_z}, 64'd0);
    check("rst_m_x", {32'd0, m_x}, 64'd0);
    @(posedge clk);
    #1;

    cfg(CFG_C0, 32'd10);
    cfg(CFG_C1, 32'd1);
    cfg(CFG_C2, 32'd1);
    cfg(CFG_COMMIT, 32'd0);
    wait_idle();

    // Backpressure: 4 accepted while m_ready=0, then the last two once slots free.
    m_ready = 1'b0;
    idx = 0;
    s_valid = 1'b1;
    s_x = xs[0];
    for (int c = 0; c < 40 && idx < 6; c++) begin
      @(negedge clk);
      acc = s_ready;
      if (c == 12) begin
        check("bp_accepted", 64'(idx), 64'd4);
        check("bp_s_ready_low", {63'd0, s_ready}, 64'd0);
      end
      @(posedge clk);
      if (acc) begin
        exp_q.push_back({zs[idx], xs[idx]});
        idx++;
      end
      #1;
      if (c == 11) m_ready = 1'b1;
      if (idx < 6) s_x = xs[idx];
      else s_valid = 1'b0;
    end
    s_valid = 1'b0;
    wait_drain();
`ifdef HORNER_ISSUE_STATS_EN
    check("stat_issued", {32'd0, stat_issued}, 64'd6);
    check("stat_stall", {32'd0, stat_stall}, 64'd9);
`endif

    // Basic stream and first-result latency.
    m_ready = 1'b1;
    send(32'd1, 32'd12, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_wait", {63'd0, m_valid}, 64'd0);
    end
    @(negedge clk);
    check("lat_valid", {63'd0, m_valid}, 64'd1);
    @(posedge clk);
    #1;
    send(32'd2, 32'd16, 1'b1);
    send(32'd3, 32'd22, 1'b1);
    wait_drain();

    // Same-edge issue and commit: sample uses old coefficients.
    cfg(CFG_C0, 32'd0);
    s_valid = 1'b1;
    s_x = 32'd3;
    cfg_we = 1'b1;
    cfg_addr = CFG_COMMIT;
    cfg_wdata = '0;
    @(negedge clk);
    check("same_edge_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back({32'd22, 32'd3});
    #1;
    s_valid = 1'b0;
    cfg_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("drain_busy", {63'd0, cfg_busy}, 64'd1);
      if (k == 0) begin
        check("drain_s_ready", {63'd0, s_ready}, 64'd0);
        check("issue_old_c0", {32'd0, ev_c0}, 64'd10);
      end
    end
    @(negedge clk);
    check("drain_done", {63'd0, cfg_busy}, 64'd0);
    @(posedge clk);
    #1;
    send(32'd3, 32'd12, 1'b1);
    wait_drain();

    // Shadow writes take effect only after commit.
    cfg(CFG_C0, 32'd10);
    cfg(CFG_C1, 32'd5);
    send(32'd2, 32'd6, 1'b1);
    wait_drain();
    cfg(CFG_COMMIT, 32'd0);
    wait_idle();
    send(32'd2, 32'd24, 1'b1);
    wait_drain();

    // Reset mid-flight: one result queued, two in the pipeline, all discarded.
    m_ready = 1'b0;
    send(32'd1, 32'd0, 1'b0);
    send(32'd2, 32'd0, 1'b0);
    send(32'd3, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, m_valid}, 64'd0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    check("post_rst_busy", {63'd0, cfg_busy}, 64'd0);
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale", {63'd0, m_valid}, 64'd0);
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
